// File: rtl/edp_diag_pkg.sv
// Shared types and sizes for the EBUS-side EDP diagnostic reader.
package edp_diag_pkg;

    localparam int unsigned DIAG_SEL_W = 3;
    localparam int unsigned EBUS_W     = 36;
    localparam int unsigned NUM_SEL    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSettle,
        StCapture,
        StGap,
        StDone
    } state_e;

endpackage

// File: rtl/edp_diag_reader_if.sv
// Front-end request/readback and EBUS diagnostic signals of the EDP diag reader.
// master: console front end plus the EDP slices; slave: the reader itself.
interface edp_diag_reader_if;
    import edp_diag_pkg::*;

    logic                  start_h;
    logic                  burst_h;
    logic [DIAG_SEL_W-1:0] func_sel_h;
    logic                  abort_h;
    logic [EBUS_W-1:0]     ebus_d_h;
    logic                  diag_read_func_12x_h;
    logic                  diag_04_a_h;
    logic                  diag_05_a_h;
    logic                  diag_06_a_h;
    logic                  busy_h;
    logic                  done_h;
    logic                  aborted_h;
    logic [EBUS_W-1:0]     data_h;
    logic [DIAG_SEL_W-1:0] rd_idx_h;
    logic [EBUS_W-1:0]     rd_data_h;
    logic [NUM_SEL-1:0]    valid_h;

    modport master (
        output start_h, burst_h, func_sel_h, abort_h, ebus_d_h, rd_idx_h,
        input  diag_read_func_12x_h, diag_04_a_h, diag_05_a_h, diag_06_a_h,
        input  busy_h, done_h, aborted_h, data_h, rd_data_h, valid_h
    );

    modport slave (
        input  start_h, burst_h, func_sel_h, abort_h, ebus_d_h, rd_idx_h,
        output diag_read_func_12x_h, diag_04_a_h, diag_05_a_h, diag_06_a_h,
        output busy_h, done_h, aborted_h, data_h, rd_data_h, valid_h
    );

endinterface

// File: rtl/edp_diag_buf.sv
// 8 x 36 capture buffer with per-entry valid bits and a combinational read port.
module edp_diag_buf
    import edp_diag_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DIAG_SEL_W-1:0] idx,
    input  logic [EBUS_W-1:0]     data,
    input  logic                  clr_valid,
    input  logic [DIAG_SEL_W-1:0] rd_idx,
    output logic [EBUS_W-1:0]     rd_data,
    output logic [NUM_SEL-1:0]    valid
);

    logic [EBUS_W-1:0]  mem_q [NUM_SEL];
    logic [NUM_SEL-1:0] valid_q, valid_d;

    // Storage is not reset; only the valid mask says which entries mean anything.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= data;
        end
    end

    // Clear-all happens first so a clear and a write in one cycle leave only the new entry.
    always_comb begin
        valid_d = valid_q;
        if (clr_valid) begin
            valid_d = '0;
        end
        if (we) begin
            valid_d[idx] = 1'b1;
        end
    end

    // Valid mask register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign rd_data = mem_q[rd_idx];
    assign valid   = valid_q;

endmodule

// File: rtl/edp_diag_reader.sv
// EBUS-side initiator for EDP diagnostic reads: drives the read function and
// select to the EDP slices, waits for EBUS to settle, then captures the word.
module edp_diag_reader
    import edp_diag_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned CNT_W      = 4
) (
    input logic              clk_h,
    input logic              crobar_h,
    edp_diag_reader_if.slave bus
);

    localparam logic [CNT_W-1:0]      SettleLoad = CNT_W'(SETTLE_CYC - 1);
    localparam logic [DIAG_SEL_W-1:0] LastSel    = DIAG_SEL_W'(NUM_SEL - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DIAG_SEL_W-1:0] sel_q, sel_d;
    logic                  burst_q, burst_d;
    logic                  aborted_q, aborted_d;
    logic [EBUS_W-1:0]     data_q;
    logic                  cap_we;
    logic                  clr_valid;
    logic                  sel_active;

    // State, counter, select and captured-word registers.
    always_ff @(posedge clk_h) begin
        if (crobar_h) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= '0;
            burst_q   <= 1'b0;
            aborted_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            burst_q   <= burst_d;
            aborted_q <= aborted_d;
            if (cap_we) begin
                data_q <= bus.ebus_d_h;
            end
        end
    end

    // Next-state logic; abort overrides every transition out of a busy state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        burst_d   = burst_q;
        aborted_d = 1'b0;
        cap_we    = 1'b0;
        clr_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_h) begin
                    burst_d   = bus.burst_h;
                    sel_d     = bus.burst_h ? '0 : bus.func_sel_h;
                    clr_valid = bus.burst_h;
                    state_d   = StSetup;
                end
            end
            StSetup: begin
                cnt_d   = SettleLoad;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StCapture: begin
                cap_we  = 1'b1;
                state_d = (!burst_q || sel_q == LastSel) ? StDone : StGap;
            end
            StGap: begin
                sel_d   = sel_q + 1'b1;
                state_d = StSetup;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // An abort must not disturb data_h or the buffer, so the capture is suppressed too.
        if (state_q != StIdle && bus.abort_h) begin
            state_d   = StIdle;
            sel_d     = sel_q;
            cap_we    = 1'b0;
            clr_valid = 1'b0;
            aborted_d = 1'b1;
        end
    end

    // Select is driven from SETUP through GAP; it only moves while the function is low.
    always_comb begin
        sel_active = (state_q == StSetup) || (state_q == StSettle) ||
                     (state_q == StCapture) || (state_q == StGap);
    end

    assign bus.diag_read_func_12x_h = (state_q == StSettle) || (state_q == StCapture);
    assign bus.diag_04_a_h          = sel_active & sel_q[2];
    assign bus.diag_05_a_h          = sel_active & sel_q[1];
    assign bus.diag_06_a_h          = sel_active & sel_q[0];
    assign bus.busy_h               = sel_active;
    assign bus.done_h               = (state_q == StDone);
    assign bus.aborted_h            = aborted_q;
    assign bus.data_h               = data_q;

    edp_diag_buf u_buf (
        .clk       (clk_h),
        .rst       (crobar_h),
        .we        (cap_we),
        .idx       (sel_q),
        .data      (bus.ebus_d_h),
        .clr_valid (clr_valid),
        .rd_idx    (bus.rd_idx_h),
        .rd_data   (bus.rd_data_h),
        .valid     (bus.valid_h)
    );

endmodule

// File: tb/tb_edp_diag_reader.sv
// Self-checking bench for edp_diag_reader: table vectors, random reads against a
// buffer/valid model, and hand-written abort, restart and reset sequences.
module tb_edp_diag_reader;

    localparam int S4 = 4;
    localparam int S1 = 1;
    localparam logic [35:0] IDLE_PAT = 36'o525252525252;

    logic clk = 1'b0;
    logic rst4;
    logic rst1;

    always #5 clk = ~clk;

    edp_diag_reader_if bus4 ();
    edp_diag_reader_if bus1 ();

    edp_diag_reader #(.SETTLE_CYC(S4), .CNT_W(4)) u_dut4 (
        .clk_h    (clk),
        .crobar_h (rst4),
        .bus      (bus4)
    );

    edp_diag_reader #(.SETTLE_CYC(S1), .CNT_W(4)) u_dut1 (
        .clk_h    (clk),
        .crobar_h (rst1),
        .bus      (bus1)
    );

    // EDP slice model: each select returns its own word while the read function is active.
    logic [35:0] edp_word [8];

    assign bus4.ebus_d_h = bus4.diag_read_func_12x_h ?
        edp_word[{bus4.diag_04_a_h, bus4.diag_05_a_h, bus4.diag_06_a_h}] : IDLE_PAT;
    assign bus1.ebus_d_h = bus1.diag_read_func_12x_h ?
        edp_word[{bus1.diag_04_a_h, bus1.diag_05_a_h, bus1.diag_06_a_h}] : IDLE_PAT;

    // Reference model of DUT4's visible capture state.
    logic [35:0] ref_buf [8];
    logic [7:0]  ref_valid;
    logic [35:0] ref_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [35:0] word;
        logic [2:0]  exp_lines;
        logic [7:0]  exp_valid;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] lines4();
        return {bus4.diag_04_a_h, bus4.diag_05_a_h, bus4.diag_06_a_h};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request on DUT4 for a fixed window and records what the EBUS side saw.
    task automatic run4(input bit burst, input logic [2:0] sel, input bit restart,
                        input logic [2:0] sel2, input bit abort0,
                        output int done_cnt, output int done_at, output int fruns,
                        output int fhi, output bit sel_bad, output logic [2:0] lines_first);
        int lat;
        int exp_sel;
        bit prev_f;
        logic [2:0] lines;
        lat         = burst ? 8 * (S4 + 2) + 8 : S4 + 3;
        done_cnt    = 0;
        done_at     = -1;
        fruns       = 0;
        fhi         = 0;
        sel_bad     = 1'b0;
        lines_first = '0;
        prev_f      = 1'b0;
        bus4.burst_h    = burst;
        bus4.func_sel_h = sel;
        bus4.abort_h    = abort0;
        bus4.start_h    = 1'b1;
        for (int cyc = 1; cyc <= lat + 4; cyc++) begin
            tick();
            bus4.abort_h = 1'b0;
            bus4.start_h = restart && (cyc <= lat);
            if (restart) begin
                bus4.func_sel_h = sel2;
            end
            lines = lines4();
            if (bus4.diag_read_func_12x_h) begin
                if (!prev_f) begin
                    fruns++;
                    if (fruns == 1) begin
                        lines_first = lines;
                    end
                end
                fhi++;
                exp_sel = burst ? fruns - 1 : int'(sel);
                if (lines !== 3'(exp_sel)) begin
                    sel_bad = 1'b1;
                end
            end
            if (bus4.done_h) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                end
                if (lines !== 3'b000) begin
                    sel_bad = 1'b1;
                end
            end
            prev_f = bus4.diag_read_func_12x_h;
        end
        bus4.start_h = 1'b0;
        bus4.burst_h = 1'b0;
    endtask

    task automatic compare_buffer(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (ref_valid[i]) begin
                bus4.rd_idx_h = 3'(i);
                @(negedge clk);
                check($sformatf("%s_rd%0d", tag, i), bus4.rd_data_h, ref_buf[i]);
            end
        end
        check({tag, "_valid"}, 36'(bus4.valid_h), 36'(ref_valid));
        check({tag, "_data"}, bus4.data_h, ref_data);
        check({tag, "_busy"}, 36'(bus4.busy_h), 36'd0);
        tick();
    endtask

    task automatic single4(input logic [2:0] sel, input bit restart, input logic [2:0] sel2,
                           input bit abort0, input string tag, output logic [2:0] lines_first);
        int  done_cnt, done_at, fruns, fhi;
        bit  sel_bad;
        run4(1'b0, sel, restart, sel2, abort0, done_cnt, done_at, fruns, fhi, sel_bad,
             lines_first);
        check({tag, "_done_cnt"}, 36'(done_cnt), 36'd1);
        check({tag, "_done_lat"}, 36'(done_at), 36'(S4 + 3));
        check({tag, "_func_cyc"}, 36'(fhi), 36'(S4 + 1));
        check({tag, "_sel_stable"}, 36'(sel_bad), 36'd0);
        ref_valid[sel] = 1'b1;
        ref_buf[sel]   = edp_word[sel];
        ref_data       = edp_word[sel];
        compare_buffer(tag);
    endtask

    task automatic burst4(input string tag);
        int  done_cnt, done_at, fruns, fhi;
        bit  sel_bad;
        logic [2:0] lf;
        run4(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, done_cnt, done_at, fruns, fhi, sel_bad, lf);
        check({tag, "_done_cnt"}, 36'(done_cnt), 36'd1);
        check({tag, "_done_lat"}, 36'(done_at), 36'(8 * (S4 + 2) + 8));
        check({tag, "_func_runs"}, 36'(fruns), 36'd8);
        check({tag, "_func_cyc"}, 36'(fhi), 36'(8 * (S4 + 1)));
        check({tag, "_sel_order"}, 36'(sel_bad), 36'd0);
        for (int i = 0; i < 8; i++) begin
            ref_buf[i] = edp_word[i];
        end
        ref_valid = 8'hFF;
        ref_data  = edp_word[7];
        compare_buffer(tag);
    endtask

    task automatic abort_test();
        bit found;
        int ndone;
        int nab;
        found = 1'b0;
        ndone = 0;
        nab   = 0;
        for (int i = 0; i < 8; i++) begin
            edp_word[i] = 36'(36'o700000000000 + i * 36'o1111);
        end
        bus4.burst_h = 1'b1;
        bus4.start_h = 1'b1;
        tick();
        bus4.start_h = 1'b0;
        bus4.burst_h = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (bus4.diag_read_func_12x_h && lines4() == 3'd3) begin
                found = 1'b1;
            end else begin
                tick();
            end
        end
        check("abort_reach_sel3", 36'(found), 36'd1);
        bus4.abort_h = 1'b1;
        tick();
        bus4.abort_h = 1'b0;
        check("abort_pulse", 36'(bus4.aborted_h), 36'd1);
        check("abort_no_done", 36'(bus4.done_h), 36'd0);
        check("abort_func_low", 36'(bus4.diag_read_func_12x_h), 36'd0);
        check("abort_busy", 36'(bus4.busy_h), 36'd0);
        check("abort_valid", 36'(bus4.valid_h), 36'h07);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus4.done_h) ndone++;
            if (bus4.aborted_h) nab++;
        end
        check("abort_later_done", 36'(ndone), 36'd0);
        check("abort_single_pulse", 36'(nab), 36'd0);
        ref_valid = 8'h07;
        for (int i = 0; i < 3; i++) begin
            ref_buf[i] = edp_word[i];
        end
        ref_data = edp_word[2];
        compare_buffer("abort");
    endtask

    initial begin
        logic [2:0]  lf;
        logic [63:0] r;
        logic [2:0]  rs;
        int          fhi1;
        int          done1;

        vecs[0] = '{sel: 3'b101, word: 36'o123456701234, exp_lines: 3'b101, exp_valid: 8'h20};
        vecs[1] = '{sel: 3'b000, word: 36'o000000000000, exp_lines: 3'b000, exp_valid: 8'h21};
        vecs[2] = '{sel: 3'b111, word: 36'o777777777777, exp_lines: 3'b111, exp_valid: 8'hA1};
        vecs[3] = '{sel: 3'b010, word: 36'o400000000001, exp_lines: 3'b010, exp_valid: 8'hA5};

        for (int i = 0; i < 8; i++) begin
            edp_word[i] = '0;
            ref_buf[i]  = '0;
        end
        ref_valid = '0;
        ref_data  = '0;

        rst4 = 1'b1;
        rst1 = 1'b1;
        bus4.start_h = 1'b0; bus4.burst_h = 1'b0; bus4.func_sel_h = '0;
        bus4.abort_h = 1'b0; bus4.rd_idx_h = '0;
        bus1.start_h = 1'b0; bus1.burst_h = 1'b0; bus1.func_sel_h = '0;
        bus1.abort_h = 1'b0; bus1.rd_idx_h = '0;
        tick();
        tick();
        rst4 = 1'b0;
        rst1 = 1'b0;
        tick();

        check("rst_busy", 36'(bus4.busy_h), 36'd0);
        check("rst_done", 36'(bus4.done_h), 36'd0);
        check("rst_func", 36'(bus4.diag_read_func_12x_h), 36'd0);
        check("rst_sel", 36'(lines4()), 36'd0);
        check("rst_data", bus4.data_h, 36'd0);
        check("rst_valid", 36'(bus4.valid_h), 36'd0);
        check("rst_aborted", 36'(bus4.aborted_h), 36'd0);

        // Table of single reads; valid mask accumulates across them.
        for (int i = 0; i < 4; i++) begin
            edp_word[vecs[i].sel] = vecs[i].word;
            single4(vecs[i].sel, 1'b0, 3'd0, 1'b0, $sformatf("vec%0d", i), lf);
            check($sformatf("vec%0d_lines", i), 36'(lf), 36'(vecs[i].exp_lines));
            check($sformatf("vec%0d_valid_tbl", i), 36'(bus4.valid_h), 36'(vecs[i].exp_valid));
        end

        // Burst with word = 0o1000*sel + sel.
        for (int i = 0; i < 8; i++) begin
            edp_word[i] = 36'(i * 512 + i);
        end
        burst4("burst");

        abort_test();

        // Abort in IDLE is ignored.
        bus4.abort_h = 1'b1;
        tick();
        bus4.abort_h = 1'b0;
        check("idle_abort_ignored", 36'(bus4.aborted_h), 36'd0);

        // Start together with abort in IDLE: the start wins.
        edp_word[4] = 36'o111122223333;
        single4(3'd4, 1'b0, 3'd0, 1'b1, "start_abort", lf);

        // Start held while busy and through DONE with a different select: ignored.
        edp_word[1] = 36'o313131313131;
        edp_word[6] = 36'o646464646464;
        single4(3'd1, 1'b1, 3'd6, 1'b0, "restart", lf);

        // Reset while in CAPTURE.
        edp_word[6] = 36'o252525252525;
        bus4.func_sel_h = 3'd6;
        bus4.start_h    = 1'b1;
        tick();
        bus4.start_h = 1'b0;
        for (int c = 1; c < S4 + 2; c++) begin
            tick();
        end
        check("crobar_in_capture_func", 36'(bus4.diag_read_func_12x_h), 36'd1);
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        check("crobar_func", 36'(bus4.diag_read_func_12x_h), 36'd0);
        check("crobar_sel", 36'(lines4()), 36'd0);
        check("crobar_busy", 36'(bus4.busy_h), 36'd0);
        check("crobar_done", 36'(bus4.done_h), 36'd0);
        check("crobar_data", bus4.data_h, 36'd0);
        check("crobar_valid", 36'(bus4.valid_h), 36'd0);
        ref_valid = '0;
        ref_data  = '0;
        tick();
        single4(3'd6, 1'b0, 3'd0, 1'b0, "post_crobar", lf);

        // Random single reads and one random burst against the model.
        for (int n = 0; n < 16; n++) begin
            rs = 3'($urandom_range(0, 7));
            r  = {$urandom(), $urandom()};
            edp_word[rs] = r[35:0];
            single4(rs, 1'b0, 3'd0, 1'b0, $sformatf("rnd%0d", n), lf);
        end
        for (int i = 0; i < 8; i++) begin
            r = {$urandom(), $urandom()};
            edp_word[i] = r[35:0];
        end
        burst4("rnd_burst");

        // Minimum settle time on the second instance.
        edp_word[2] = 36'o246135702461;
        fhi1  = 0;
        done1 = -1;
        bus1.func_sel_h = 3'd2;
        bus1.start_h    = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            bus1.start_h = 1'b0;
            if (bus1.diag_read_func_12x_h) fhi1++;
            if (bus1.done_h && done1 < 0) done1 = cyc;
        end
        check("s1_func_cyc", 36'(fhi1), 36'(S1 + 1));
        check("s1_done_lat", 36'(done1), 36'(S1 + 3));
        check("s1_data", bus1.data_h, 36'o246135702461);
        check("s1_valid", 36'(bus1.valid_h), 36'h04);
        bus1.rd_idx_h = 3'd2;
        @(negedge clk);
        check("s1_rd", bus1.rd_data_h, 36'o246135702461);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
